// File: rtl/alu_op_sequencer.sv
// Command-side sequencer in front of the 2-bit ALU: registers one operation, waits a
// settle cycle, captures result and flags, and keeps sticky flags plus an op counter.
module alu_op_sequencer #(
  parameter int WIDTH = 2,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_s,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic [3:0]       res_flags,
  output logic [3:0]       sticky_flags,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aluA_q, aluA_d;
  logic [WIDTH-1:0] aluB_q, aluB_d;
  logic [SEL_W-1:0] aluS_q, aluS_d;
  logic [WIDTH-1:0] resY_q, resY_d;
  logic [3:0]       resFlags_q, resFlags_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       accept;
  logic       capture;
  logic [3:0] newFlags;

  assign accept   = (state_q == IDLE) && cmd_valid;
  assign capture  = (state_q == SETTLE);
  assign newFlags = {alu_c, alu_z, alu_n, alu_o};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = cmd_valid ? SETTLE : IDLE;
      SETTLE:  state_d = RESULT;
      RESULT:  state_d = res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == RESULT);
  end

  // A clear coinciding with a capture still keeps the freshly captured flags.
  always_comb begin
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluS_d     = aluS_q;
    resY_d     = resY_q;
    resFlags_d = resFlags_q;
    count_d    = count_q;
    sticky_d   = clr_sticky ? 4'b0000 : sticky_q;
    if (accept) begin
      aluA_d = cmd_a;
      aluB_d = cmd_b;
      aluS_d = cmd_s;
    end
    if (capture) begin
      resY_d     = alu_y;
      resFlags_d = newFlags;
      sticky_d   = sticky_d | newFlags;
      count_d    = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluS_q     <= '0;
      resY_q     <= '0;
      resFlags_q <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluS_q     <= aluS_d;
      resY_q     <= resY_d;
      resFlags_q <= resFlags_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign alu_a        = aluA_q;
  assign alu_b        = aluB_q;
  assign alu_s        = aluS_q;
  assign res_y        = resY_q;
  assign res_flags    = resFlags_q;
  assign sticky_flags = sticky_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: the bench plays the ALU, queues each expected
// capture when a command is driven and pops it when res_valid appears.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic [1:0] cmd_s;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [1:0] alu_s;
  logic [1:0] alu_y;
  logic       alu_c;
  logic       alu_z;
  logic       alu_n;
  logic       alu_o;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_y;
  logic [3:0] res_flags;
  logic [3:0] sticky_flags;
  logic       clr_sticky;
  logic [7:0] op_count;

  int         checks;
  int         errors;
  logic [5:0] scoreboard[$];
  logic [7:0] expCount;
  logic [3:0] expSticky;

  alu_op_sequencer #(.WIDTH(2), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_o(alu_o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_flags(res_flags),
    .sticky_flags(sticky_flags), .clr_sticky(clr_sticky),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected,
               $time);
    end
  endtask

  // One full operation: drive the command, play the ALU, check the capture, then
  // optionally stall the result port while disturbing every input that must be ignored.
  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] s, input logic [1:0] y,
                               input logic [3:0] f, input int stall,
                               input bit clrOnCapture);
    logic [5:0] exp;
    int         waitCycles;
    @(negedge clk);
    checkOutput("cmdReadyIdle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_s = s;
    alu_y = y;
    {alu_c, alu_z, alu_n, alu_o} = f;
    scoreboard.push_back({y, f});
    expCount  = expCount + 8'd1;
    expSticky = clrOnCapture ? f : (expSticky | f);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("aluA", 32'(alu_a), 32'(a));
    checkOutput("aluB", 32'(alu_b), 32'(b));
    checkOutput("aluS", 32'(alu_s), 32'(s));
    checkOutput("settleNoValid", 32'(res_valid), 0);
    checkOutput("settleNotReady", 32'(cmd_ready), 0);
    clr_sticky = clrOnCapture;
    @(negedge clk);
    clr_sticky = 1'b0;
    waitCycles = 0;
    while (!res_valid && waitCycles < 8) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("latency", 32'(waitCycles), 0);
    if (res_valid && scoreboard.size() > 0) begin
      exp = scoreboard.pop_front();
      checkOutput("resY", 32'(res_y), 32'(exp[5:4]));
      checkOutput("resFlags", 32'(res_flags), 32'(exp[3:0]));
      checkOutput("opCount", 32'(op_count), 32'(expCount));
      checkOutput("sticky", 32'(sticky_flags), 32'(expSticky));
    end else begin
      checkOutput("resTimeout", 32'(res_valid), 1);
      exp = {y, f};
    end
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      cmd_a = ~a;
      cmd_b = ~b;
      alu_y = ~y;
      {alu_c, alu_z, alu_n, alu_o} = ~f;
      @(negedge clk);
      checkOutput("stallValid", 32'(res_valid), 1);
      checkOutput("stallNotReady", 32'(cmd_ready), 0);
      checkOutput("stallResY", 32'(res_y), 32'(exp[5:4]));
      checkOutput("stallFlags", 32'(res_flags), 32'(exp[3:0]));
      checkOutput("stallAluA", 32'(alu_a), 32'(a));
      checkOutput("stallCount", 32'(op_count), 32'(expCount));
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("doneNoValid", 32'(res_valid), 0);
    checkOutput("doneReady", 32'(cmd_ready), 1);
    checkOutput("holdResY", 32'(res_y), 32'(exp[5:4]));
    checkOutput("holdAluB", 32'(alu_b), 32'(b));
  endtask

  initial begin
    logic [1:0] a;
    logic [1:0] b;
    checks = 0;
    errors = 0;
    expCount = 8'd0;
    expSticky = 4'd0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 2'd0;
    cmd_b = 2'd0;
    cmd_s = 2'd0;
    alu_y = 2'd0;
    {alu_c, alu_z, alu_n, alu_o} = 4'd0;
    res_ready = 1'b0;
    clr_sticky = 1'b0;
    #2;
    checkOutput("rstReady", 32'(cmd_ready), 1);
    checkOutput("rstValid", 32'(res_valid), 0);
    checkOutput("rstCount", 32'(op_count), 0);
    checkOutput("rstSticky", 32'(sticky_flags), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic operation with 5-cycle backpressure");
    applyStimulus(2'b01, 2'b10, 2'b01, 2'b11, 4'b0010, 5, 1'b0);
    checkOutput("basicCount", 32'(op_count), 1);

    $display("[TB] sticky accumulation and clear");
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    expSticky = 4'd0;
    checkOutput("idleClear", 32'(sticky_flags), 0);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 4'b1000, 0, 1'b0);
    applyStimulus(2'b11, 2'b01, 2'b10, 2'b01, 4'b0100, 1, 1'b0);
    applyStimulus(2'b10, 2'b11, 2'b11, 2'b10, 4'b0001, 0, 1'b0);
    checkOutput("sticky1101", 32'(sticky_flags), 32'h0000000d);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b10, 4'b0010, 0, 1'b1);
    checkOutput("sticky0010", 32'(sticky_flags), 2);

    $display("[TB] reset while a result is pending");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 2'b11;
    cmd_b = 2'b11;
    cmd_s = 2'b01;
    alu_y = 2'b10;
    {alu_c, alu_z, alu_n, alu_o} = 4'b1001;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("preRstValid", 32'(res_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", 32'(res_valid), 0);
    checkOutput("midRstReady", 32'(cmd_ready), 1);
    checkOutput("midRstCount", 32'(op_count), 0);
    checkOutput("midRstSticky", 32'(sticky_flags), 0);
    checkOutput("midRstResY", 32'(res_y), 0);
    checkOutput("midRstFlags", 32'(res_flags), 0);
    checkOutput("midRstAluA", 32'(alu_a), 0);
    @(negedge clk);
    rst = 1'b0;
    scoreboard.delete();
    expCount = 8'd0;
    expSticky = 4'd0;
    @(negedge clk);
    checkOutput("postRstNoValid", 32'(res_valid), 0);
    applyStimulus(2'b10, 2'b01, 2'b01, 2'b11, 4'b0000, 0, 1'b0);
    checkOutput("postRstCount", 32'(op_count), 1);

    $display("[TB] operand sweep and counter wrap");
    for (int i = 0; i < 255; i++) begin
      if (i < 16) begin
        a = 2'(i >> 2);
        b = 2'(i);
        applyStimulus(a, b, 2'b01, a + b, 4'($urandom_range(0, 15)), 0, 1'b0);
      end else begin
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
        applyStimulus(a, b, 2'($urandom_range(0, 3)), a ^ b, 4'($urandom_range(0, 15)),
                      (i % 17 == 0) ? 2 : 0, 1'b0);
      end
    end
    checkOutput("wrapZero", 32'(op_count), 0);
    checkOutput("queueEmpty", 32'(scoreboard.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
